amp_cfg_sequencer: RTL and testbench

//  Walks a table of amplifier register writes and issues them one by one over a req/ack write port to the amp control-bus master.

---
 rtl/amp_cfg_sequencer_if.sv | 39 +++
 rtl/amp_cfg_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_amp_cfg_sequencer.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/amp_cfg_sequencer_if.sv
// Write (and optional readback) bus between the config sequencer and the
// amp control-bus master.
//   master : sequencer side, drives requests and samples ack/nak/read data
//   slave  : bus-master side, drives ack/nak/read data
// Readback signals exist only when AMP_CFG_READBACK_EN is defined.
interface amp_cfg_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              wr_req_out;
    logic [ADDR_W-1:0] wr_addr_out;
    logic [DATA_W-1:0] wr_data_out;
    logic              wr_ack_in;
    logic              wr_nak_in;
`ifdef AMP_CFG_READBACK_EN
    logic              rd_req_out;
    logic [ADDR_W-1:0] rd_addr_out;
    logic              rd_ack_in;
    logic [DATA_W-1:0] rd_data_in;

    modport master (
        output wr_req_out, wr_addr_out, wr_data_out, rd_req_out, rd_addr_out,
        input  wr_ack_in, wr_nak_in, rd_ack_in, rd_data_in
    );
    modport slave (
        input  wr_req_out, wr_addr_out, wr_data_out, rd_req_out, rd_addr_out,
        output wr_ack_in, wr_nak_in, rd_ack_in, rd_data_in
    );
`else
    modport master (
        output wr_req_out, wr_addr_out, wr_data_out,
        input  wr_ack_in, wr_nak_in
    );
    modport slave (
        input  wr_req_out, wr_addr_out, wr_data_out,
        output wr_ack_in, wr_nak_in
    );
`endif
endinterface

// File: rtl/amp_cfg_sequencer.sv
// amp_cfg_sequencer: walks a table of amplifier register writes and issues
// them one at a time over a req/ack write port, with per-entry retries, a
// bus timeout and abort on start_in low.
// Optional feature macro: AMP_CFG_READBACK_EN (adds VERIFY readback state).
// Ports:
//   clk_in, resetb        clock, async active-low reset
//   start_in              level; rising edge starts, low while busy aborts
//   tbl_idx_out           table index; tbl_addr_in/tbl_data_in read back comb.
//   bus (master modport)  write request/ack/nak (+ readback when enabled)
//   busy_out/done_out/error_out/fail_idx_out   status to amp state control
//
// state  | meaning
// IDLE   | waiting for a start edge
// FETCH  | latch table entry at idx, load timeout
// REQ    | write request held until ack, nak or timeout
// VERIFY | readback of the written entry (AMP_CFG_READBACK_EN only)
// RETRY  | retry the same entry or give up
// NEXT   | advance idx or finish
// DONE   | all entries written, wait for start edge
// ERROR  | entry failed after retries, wait for start edge
module amp_cfg_sequencer #(
    parameter int NUM_WRITES  = 8,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 1024,
    parameter int MAX_RETRY   = 3,
    localparam int IDX_W = (NUM_WRITES > 1) ? $clog2(NUM_WRITES) : 1
) (
    input  logic               clk_in,
    input  logic               resetb,
    input  logic               start_in,
    output logic [IDX_W-1:0]   tbl_idx_out,
    input  logic [ADDR_W-1:0]  tbl_addr_in,
    input  logic [DATA_W-1:0]  tbl_data_in,
    amp_cfg_sequencer_if.master bus,
    output logic               busy_out,
    output logic               done_out,
    output logic               error_out,
    output logic [IDX_W-1:0]   fail_idx_out
);
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYC);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_WRITES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_REQ    = 3'd2,
        S_RETRY  = 3'd3,
        S_NEXT   = 3'd4,
        S_DONE   = 3'd5,
`ifdef AMP_CFG_READBACK_EN
        S_ERROR  = 3'd6,
        S_VERIFY = 3'd7
`else
        S_ERROR  = 3'd6
`endif
    } state_t;

    state_t            state_q, state_d;
    logic              start_q, start_d;
    logic              abort_q, abort_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [RTY_W-1:0]  retry_q, retry_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [IDX_W-1:0]  fail_idx_q, fail_idx_d;

    logic start_edge;
    logic abort_now;
    logic tmo_done;
    logic busy;

    always_ff @(posedge clk_in or negedge resetb) begin
        if (!resetb) begin
            state_q    <= S_IDLE;
            start_q    <= 1'b0;
            abort_q    <= 1'b0;
            idx_q      <= '0;
            retry_q    <= '0;
            tmo_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            fail_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            abort_q    <= abort_d;
            idx_q      <= idx_d;
            retry_q    <= retry_d;
            tmo_q      <= tmo_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            fail_idx_q <= fail_idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        start_d    = start_in;
        abort_d    = abort_q;
        idx_d      = idx_q;
        retry_d    = retry_q;
        tmo_d      = tmo_q;
        addr_d     = addr_q;
        data_d     = data_q;
        fail_idx_d = fail_idx_q;

        start_edge = start_in & ~start_q;
        busy       = (state_q == S_FETCH) || (state_q == S_REQ) ||
                     (state_q == S_RETRY) || (state_q == S_NEXT);
`ifdef AMP_CFG_READBACK_EN
        busy       = busy || (state_q == S_VERIFY);
`endif
        // Abort is sticky so a re-raised start during a pending handshake
        // still ends the sequence once the handshake completes.
        if (busy && !start_in) begin
            abort_d = 1'b1;
        end
        abort_now = abort_q | ~start_in;
        tmo_done  = (tmo_q == '0);

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start_edge) begin
                    state_d = S_FETCH;
                    idx_d   = '0;
                    retry_d = '0;
                    abort_d = 1'b0;
                end
            end
            S_FETCH: begin
                if (abort_now) begin
                    state_d = S_IDLE;
                    abort_d = 1'b0;
                end else begin
                    addr_d  = tbl_addr_in;
                    data_d  = tbl_data_in;
                    tmo_d   = TMO_LOAD;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // ack has priority over a simultaneous nak
                if (bus.wr_ack_in) begin
                    if (abort_now) begin
                        state_d = S_IDLE;
                        abort_d = 1'b0;
                    end else begin
`ifdef AMP_CFG_READBACK_EN
                        tmo_d   = TMO_LOAD;
                        state_d = S_VERIFY;
`else
                        state_d = S_NEXT;
`endif
                    end
                end else if (bus.wr_nak_in || tmo_done) begin
                    if (abort_now) begin
                        state_d = S_IDLE;
                        abort_d = 1'b0;
                    end else begin
                        state_d = S_RETRY;
                    end
                end else begin
                    tmo_d = tmo_q - TMO_W'(1);
                end
            end
`ifdef AMP_CFG_READBACK_EN
            S_VERIFY: begin
                if (bus.rd_ack_in || tmo_done) begin
                    if (abort_now) begin
                        state_d = S_IDLE;
                        abort_d = 1'b0;
                    end else if (bus.rd_ack_in && (bus.rd_data_in == data_q)) begin
                        state_d = S_NEXT;
                    end else begin
                        state_d = S_RETRY;
                    end
                end else begin
                    tmo_d = tmo_q - TMO_W'(1);
                end
            end
`endif
            S_RETRY: begin
                if (abort_now) begin
                    state_d = S_IDLE;
                    abort_d = 1'b0;
                end else if (retry_q < RTY_W'(MAX_RETRY)) begin
                    retry_d = retry_q + RTY_W'(1);
                    tmo_d   = TMO_LOAD;
                    state_d = S_REQ;
                end else begin
                    fail_idx_d = idx_q;
                    state_d    = S_ERROR;
                end
            end
            S_NEXT: begin
                retry_d = '0;
                if (abort_now) begin
                    state_d = S_IDLE;
                    abort_d = 1'b0;
                end else if (idx_q == IDX_LAST) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign tbl_idx_out     = idx_q;
    assign bus.wr_req_out  = (state_q == S_REQ);
    assign bus.wr_addr_out = addr_q;
    assign bus.wr_data_out = data_q;
`ifdef AMP_CFG_READBACK_EN
    assign bus.rd_req_out  = (state_q == S_VERIFY);
    assign bus.rd_addr_out = addr_q;
`endif
    assign busy_out        = busy;
    assign done_out        = (state_q == S_DONE);
    assign error_out       = (state_q == S_ERROR);
    assign fail_idx_out    = fail_idx_q;

endmodule

// File: tb/tb_amp_cfg_sequencer.sv
// Bench for amp_cfg_sequencer: scenario table with a scripted bus responder,
// plus hand-written abort and async-reset sequences.
module tb_amp_cfg_sequencer;
    localparam int NW  = 4;
    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int TMO = 16;
    localparam int MR  = 3;
    localparam int IW  = 2;

    logic          clk_in = 1'b0;
    logic          resetb = 1'b0;
    logic          start_in = 1'b0;
    logic [IW-1:0] tbl_idx_out;
    logic [AW-1:0] tbl_addr_in;
    logic [DW-1:0] tbl_data_in;
    logic          busy_out, done_out, error_out;
    logic [IW-1:0] fail_idx_out;

    logic [AW-1:0] tbl_addr [NW];
    logic [DW-1:0] tbl_data [NW];

    amp_cfg_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    amp_cfg_sequencer #(
        .NUM_WRITES (NW),
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .TIMEOUT_CYC(TMO),
        .MAX_RETRY  (MR)
    ) dut (
        .clk_in      (clk_in),
        .resetb      (resetb),
        .start_in    (start_in),
        .tbl_idx_out (tbl_idx_out),
        .tbl_addr_in (tbl_addr_in),
        .tbl_data_in (tbl_data_in),
        .bus         (bus),
        .busy_out    (busy_out),
        .done_out    (done_out),
        .error_out   (error_out),
        .fail_idx_out(fail_idx_out)
    );

    assign tbl_addr_in = tbl_addr[tbl_idx_out];
    assign tbl_data_in = tbl_data[tbl_idx_out];

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Responder script: nak_idx gets nak_cnt naks first, dead_idx is never
    // answered, both_idx sees ack and nak together, rb_bad_idx reads back
    // corrupted data once. exp_att lists write attempts, entry 3 down to 0.
    typedef struct packed {
        int              nak_idx;
        int              nak_cnt;
        int              dead_idx;
        int              both_idx;
        int              rb_bad_idx;
        bit              exp_done;
        bit              exp_err;
        bit [IW-1:0]     exp_fail;
        bit [NW-1:0][7:0] exp_att;
        int              exp_cycles;
        int              exp_acks;
    } vec_t;

    vec_t vecs[$];

    task automatic run_vec(input int vi, input vec_t v);
        int att[NW];
        int exp_idx   = 0;
        int run_len   = 0;
        int run_entry = 0;
        int cycles    = 0;
        int first_req = -1;
        int exp_cyc   = v.exp_cycles;
        bit prev_req  = 1'b0;
        bit prev_busy = 1'b0;
        bit prev_done = 1'b0;
        bit prev_err  = 1'b0;
        bit finished  = 1'b0;
`ifdef AMP_CFG_READBACK_EN
        bit prev_rd   = 1'b0;
        bit rb_used   = 1'b0;
        exp_cyc = exp_cyc + v.exp_acks;
`endif
        foreach (att[i]) att[i] = 0;

        @(negedge clk_in);
        start_in = 1'b1;
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            @(negedge clk_in);
            bus.wr_ack_in = 1'b0;
            bus.wr_nak_in = 1'b0;
`ifdef AMP_CFG_READBACK_EN
            bus.rd_ack_in = 1'b0;
`endif
            if (cyc == 0) begin
                check($sformatf("v%0d_start_clr", vi), {busy_out, done_out, error_out}, 3'b100);
            end
            if (busy_out) cycles++;

            if (bus.wr_req_out) begin
                if (exp_idx >= NW) begin
                    check($sformatf("v%0d_extra_req", vi), 64'(exp_idx), 64'(NW - 1));
                end else begin
                    check($sformatf("v%0d_wr_addr", vi), bus.wr_addr_out, tbl_addr[exp_idx]);
                    check($sformatf("v%0d_wr_data", vi), bus.wr_data_out, tbl_data[exp_idx]);
                    if (!prev_req) begin
                        run_len   = 1;
                        run_entry = exp_idx;
                        att[exp_idx]++;
                        if (first_req < 0) first_req = cyc;
                        if (exp_idx == v.dead_idx) begin
                            // no response: let the attempt time out
                        end else if (exp_idx == v.nak_idx && att[exp_idx] <= v.nak_cnt) begin
                            bus.wr_nak_in = 1'b1;
                        end else begin
                            bus.wr_ack_in = 1'b1;
                            if (exp_idx == v.both_idx) bus.wr_nak_in = 1'b1;
`ifndef AMP_CFG_READBACK_EN
                            exp_idx++;
`endif
                        end
                    end else begin
                        run_len++;
                    end
                end
            end else if (prev_req) begin
                check($sformatf("v%0d_req_len_e%0d", vi, run_entry), 64'(run_len),
                      (run_entry == v.dead_idx) ? 64'(TMO) : 64'd1);
            end

`ifdef AMP_CFG_READBACK_EN
            if (bus.rd_req_out && !prev_rd && exp_idx < NW) begin
                check($sformatf("v%0d_rd_addr", vi), bus.rd_addr_out, tbl_addr[exp_idx]);
                bus.rd_ack_in = 1'b1;
                if (exp_idx == v.rb_bad_idx && !rb_used) begin
                    bus.rd_data_in = tbl_data[exp_idx] ^ 8'h01;
                    rb_used = 1'b1;
                end else begin
                    bus.rd_data_in = tbl_data[exp_idx];
                    exp_idx++;
                end
            end
            prev_rd = bus.rd_req_out;
`endif

            if (done_out && !prev_done) begin
                check($sformatf("v%0d_done_busy_edge", vi), {prev_busy, busy_out}, 2'b10);
            end
            if (error_out && !prev_err) begin
                check($sformatf("v%0d_err_busy_edge", vi), {prev_busy, busy_out}, 2'b10);
            end
            finished  = done_out | error_out;
            prev_req  = bus.wr_req_out;
            prev_busy = busy_out;
            prev_done = done_out;
            prev_err  = error_out;
        end

        check($sformatf("v%0d_finished", vi), 64'(finished), 64'd1);
        check($sformatf("v%0d_done", vi), 64'(done_out), 64'(v.exp_done));
        check($sformatf("v%0d_error", vi), 64'(error_out), 64'(v.exp_err));
        if (v.exp_err) begin
            check($sformatf("v%0d_fail_idx", vi), 64'(fail_idx_out), 64'(v.exp_fail));
        end
        for (int i = 0; i < NW; i++) begin
            check($sformatf("v%0d_attempts_e%0d", vi, i), 64'(att[i]), 64'(v.exp_att[i]));
        end
        check($sformatf("v%0d_busy_cycles", vi), 64'(cycles), 64'(exp_cyc));
        check($sformatf("v%0d_first_req", vi), 64'(first_req), 64'd1);

        // start low outside busy is not an abort: status stays held
        @(negedge clk_in);
        start_in = 1'b0;
        @(negedge clk_in);
        check($sformatf("v%0d_status_held", vi), {busy_out, done_out, error_out},
              {1'b0, v.exp_done, v.exp_err});
    endtask

    initial begin
        bit seen;

        tbl_addr[0] = 8'h21; tbl_data[0] = 8'hA5;
        tbl_addr[1] = 8'h34; tbl_data[1] = 8'h3C;
        tbl_addr[2] = 8'h47; tbl_data[2] = 8'h0F;
        tbl_addr[3] = 8'h5A; tbl_data[3] = 8'hE1;
        bus.wr_ack_in = 1'b0;
        bus.wr_nak_in = 1'b0;
`ifdef AMP_CFG_READBACK_EN
        bus.rd_ack_in  = 1'b0;
        bus.rd_data_in = '0;
`endif

        //              nak nakc dead both rbbad done err fail  attempts e3..e0                  cyc acks
        vecs.push_back('{-1, 0, -1, -1, -1, 1'b1, 1'b0, 2'd0, {8'd1, 8'd1, 8'd1, 8'd1}, 12, 4});
        vecs.push_back('{ 2, 2, -1, -1, -1, 1'b1, 1'b0, 2'd0, {8'd1, 8'd3, 8'd1, 8'd1}, 16, 4});
        vecs.push_back('{-1, 0,  1, -1, -1, 1'b0, 1'b1, 2'd1, {8'd0, 8'd0, 8'd4, 8'd1}, 72, 1});
        vecs.push_back('{-1, 0, -1,  1, -1, 1'b1, 1'b0, 2'd0, {8'd1, 8'd1, 8'd1, 8'd1}, 12, 4});
        vecs.push_back('{ 0, 3, -1, -1, -1, 1'b1, 1'b0, 2'd0, {8'd1, 8'd1, 8'd1, 8'd4}, 18, 4});
        vecs.push_back('{ 3, 4, -1, -1, -1, 1'b0, 1'b1, 2'd3, {8'd4, 8'd1, 8'd1, 8'd1}, 18, 3});
`ifdef AMP_CFG_READBACK_EN
        vecs.push_back('{-1, 0, -1, -1,  0, 1'b1, 1'b0, 2'd0, {8'd1, 8'd1, 8'd1, 8'd2}, 14, 5});
`endif

        repeat (3) @(negedge clk_in);
        check("rst_outputs", {bus.wr_req_out, busy_out, done_out, error_out,
                              tbl_idx_out, fail_idx_out}, '0);
        check("rst_wr_bus", {bus.wr_addr_out, bus.wr_data_out}, '0);
        resetb = 1'b1;
        @(negedge clk_in);
        check("idle_after_rst", {bus.wr_req_out, busy_out, done_out, error_out}, 4'b0000);

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // abort while in FETCH
        @(negedge clk_in);
        start_in = 1'b1;
        @(negedge clk_in);
        check("abort_fetch_busy", {busy_out, bus.wr_req_out, done_out, error_out}, 4'b1000);
        start_in = 1'b0;
        @(negedge clk_in);
        check("abort_fetch_idle", {busy_out, bus.wr_req_out, done_out, error_out}, 4'b0000);
        repeat (3) begin
            @(negedge clk_in);
            check("abort_fetch_quiet", {busy_out, bus.wr_req_out}, 2'b00);
        end

        // abort while in REQ: request held until acked
        @(negedge clk_in);
        start_in = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk_in);
            seen = bus.wr_req_out;
        end
        check("abort_req_seen", 64'(seen), 64'd1);
        start_in = 1'b0;
        repeat (4) begin
            @(negedge clk_in);
            check("abort_req_hold", {bus.wr_req_out, bus.wr_addr_out}, {1'b1, tbl_addr[0]});
        end
        bus.wr_ack_in = 1'b1;
        @(negedge clk_in);
        bus.wr_ack_in = 1'b0;
        check("abort_req_idle", {bus.wr_req_out, busy_out, done_out, error_out}, 4'b0000);
        repeat (2) begin
            @(negedge clk_in);
            check("abort_req_quiet", {bus.wr_req_out, busy_out, done_out}, 3'b000);
        end
        run_vec(99, vecs[0]);

        // async reset mid-request drops the request without a clock edge
        @(negedge clk_in);
        start_in = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk_in);
            seen = bus.wr_req_out;
        end
        check("arst_req_seen", 64'(seen), 64'd1);
        #2;
        resetb = 1'b0;
        #1;
        check("arst_req_drop", {bus.wr_req_out, busy_out}, 2'b00);
        @(negedge clk_in);
        start_in = 1'b0;
        resetb = 1'b1;
        @(negedge clk_in);
        check("arst_idle", {bus.wr_req_out, busy_out, done_out, error_out}, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got=stalled expected=finish");
        $fatal(1, "bench timeout");
    end
endmodule
